truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_if.sv | 36 +++
 rtl/truth_table_sweeper.sv | 116 +++++++++++
 tb/tb_truth_table_sweeper.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and whoever owns the circuit under test; `table` is a reserved word, so the word is table_bits.
// TRUTH_TABLE_SWEEPER_CHECK_EN adds the expected/mismatch/err_idx signals.
interface truth_table_sweeper_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic                 f;
   logic [N_IN-1:0]      vec;
   logic                 busy;
   logic                 done;
   logic [2**N_IN-1:0]   table_bits;
   logic                 table_valid;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
   logic [2**N_IN-1:0]   expected;
   logic                 mismatch;
   logic [N_IN-1:0]      err_idx;

   modport master (
      output start, f, expected,
      input  vec, busy, done, table_bits, table_valid, mismatch, err_idx
   );
   modport slave (
      input  start, f, expected,
      output vec, busy, done, table_bits, table_valid, mismatch, err_idx
   );
`else
   modport master (
      output start, f,
      input  vec, busy, done, table_bits, table_valid
   );
   modport slave (
      input  start, f,
      output vec, busy, done, table_bits, table_valid
   );
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps vec through 0..2**N_IN-1 (HOLD+1 cycles each) and captures f into table_bits; done pulses 2+2**N_IN*(HOLD+1) cycles after start.
// No backpressure: start is only honoured in IDLE. TRUTH_TABLE_SWEEPER_CHECK_EN adds a sticky compare against expected.
module truth_table_sweeper #(
   parameter int N_IN = 3,
   parameter int HOLD = 4
) (
   input logic               clk,
   input logic               rst,
   truth_table_sweeper_if.slave bus
);
   localparam int W  = 2**N_IN;
   localparam int IW = N_IN + 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRIVE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [IW-1:0] LAST_IDX  = IW'(W - 1);
   localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);

   logic [1:0]      state;
   logic [IW-1:0]   idx;
   logic [7:0]      hold_cnt;
   logic [N_IN-1:0] vec_q;
   logic            busy_q;
   logic            done_q;
   logic            valid_q;
   logic [W-1:0]    table_q;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
   logic            mismatch_q;
   logic [N_IN-1:0] err_idx_q;
`endif

   // Outputs are registered from the current state, so they trail the state by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         hold_cnt <= '0;
         vec_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         table_q  <= '0;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
         mismatch_q <= 1'b0;
         err_idx_q  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               vec_q  <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (bus.start) begin
                  table_q  <= '0;
                  valid_q  <= 1'b0;
                  idx      <= '0;
                  hold_cnt <= '0;
                  state    <= DRIVE;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
                  mismatch_q <= 1'b0;
                  err_idx_q  <= '0;
`endif
               end
            end
            DRIVE: begin
               vec_q    <= idx[N_IN-1:0];
               busy_q   <= 1'b1;
               done_q   <= 1'b0;
               hold_cnt <= hold_cnt + 8'd1;
               if (hold_cnt == HOLD_LAST) state <= SAMPLE;
            end
            SAMPLE: begin
               vec_q  <= idx[N_IN-1:0];
               busy_q <= 1'b1;
               done_q <= 1'b0;
               table_q[idx[N_IN-1:0]] <= bus.f;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
               // Only the first failure is latched, giving the lowest failing index.
               if ((bus.f != bus.expected[idx[N_IN-1:0]]) && !mismatch_q) begin
                  mismatch_q <= 1'b1;
                  err_idx_q  <= idx[N_IN-1:0];
               end
`endif
               if (idx == LAST_IDX) begin
                  state <= DONE;
               end else begin
                  idx      <= idx + 1'b1;
                  hold_cnt <= '0;
                  state    <= DRIVE;
               end
            end
            default: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               valid_q <= 1'b1;
               vec_q   <= '0;
               idx     <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.vec         = vec_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.table_bits  = table_q;
   assign bus.table_valid = valid_q;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
   assign bus.mismatch    = mismatch_q;
   assign bus.err_idx     = err_idx_q;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweepers (N3/H4, N3/H1, N2/H4) driven against small behavioural circuits.
module tb_truth_table_sweeper;
   logic clk;
   logic rst;
   logic force4;
   int   n_cmp;
   int   n_bad;
   int   dc, nd, ve, be, k;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
   logic mm25, mm26;
`endif

   truth_table_sweeper_if #(.N_IN(3)) ia ();
   truth_table_sweeper_if #(.N_IN(3)) ib ();
   truth_table_sweeper_if #(.N_IN(2)) ic ();

   truth_table_sweeper #(.N_IN(3), .HOLD(4)) u_a (.clk(clk), .rst(rst), .bus(ia));
   truth_table_sweeper #(.N_IN(3), .HOLD(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
   truth_table_sweeper #(.N_IN(2), .HOLD(4)) u_c (.clk(clk), .rst(rst), .bus(ic));

   // Circuits under test: (a&b)|c with optional stuck-1 at vector 4, constant 1, and a^b.
   assign ia.f = (force4 && ia.vec == 3'd4) ? 1'b1 : ((ia.vec[2] & ia.vec[1]) | ia.vec[0]);
   assign ib.f = 1'b1;
   assign ic.f = ic.vec[1] ^ ic.vec[0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one sweep on u_a; cycle k is sampled at the k-th negedge after the start-sampling edge.
   task automatic sweep_a(input bit poke5, output int done_cyc, output int n_done,
                          output int vec_err, output int busy_err);
      bit poked;
      int exp_vec;
      @(negedge clk); ia.start = 1'b1;
      @(negedge clk); ia.start = 1'b0;
      done_cyc = 0; n_done = 0; vec_err = 0; busy_err = 0; poked = 1'b0;
      for (int kk = 1; kk <= 60; kk++) begin
         if (kk > 1) @(negedge clk);
         if (ia.start) ia.start = 1'b0;
         if (poke5 && !poked && ia.vec == 3'd5) begin
            ia.start = 1'b1;
            poked = 1'b1;
         end
         exp_vec = (kk >= 2 && kk <= 41) ? (kk - 2) / 5 : 0;
         if (ia.vec !== 3'(exp_vec)) vec_err++;
         if (ia.busy !== 1'(kk >= 2 && kk <= 41)) busy_err++;
         if (ia.done === 1'b1) begin
            n_done++;
            if (done_cyc == 0) done_cyc = kk;
         end
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
         if (kk == 25) mm25 = ia.mismatch;
         if (kk == 26) mm26 = ia.mismatch;
`endif
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1; force4 = 1'b0;
      ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
      ia.expected = 8'hEA; ib.expected = 8'hFF; ic.expected = 4'h6;
      mm25 = 1'b0; mm26 = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_vec",   32'(ia.vec), 32'd0);
      chk("rst_busy",  32'(ia.busy), 32'd0);
      chk("rst_done",  32'(ia.done), 32'd0);
      chk("rst_table", 32'(ia.table_bits), 32'd0);
      chk("rst_valid", 32'(ia.table_valid), 32'd0);
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
      chk("rst_mismatch", 32'(ia.mismatch), 32'd0);
      chk("rst_err_idx",  32'(ia.err_idx), 32'd0);
`endif
      rst = 1'b0;

      // Basic sweep, f = (a&b)|c -> 8'hEA
      sweep_a(1'b0, dc, nd, ve, be);
      chk("a_done_cycle", dc, 32'd42);
      chk("a_done_count", nd, 32'd1);
      chk("a_vec_seq_errs", ve, 32'd0);
      chk("a_busy_errs", be, 32'd0);
      chk("a_table", 32'(ia.table_bits), 32'hEA);
      chk("a_valid", 32'(ia.table_valid), 32'd1);
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
      chk("a_no_mismatch", 32'(ia.mismatch), 32'd0);
`endif

      // HOLD=1, f tied high
      @(negedge clk); ib.start = 1'b1;
      @(negedge clk); ib.start = 1'b0;
      k = 1;
      while (ib.done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      chk("b_done_cycle", k, 32'd18);
      chk("b_table", 32'(ib.table_bits), 32'hFF);
      chk("b_busy_at_done", 32'(ib.busy), 32'd0);

      // N_IN=2, f = a^b
      @(negedge clk); ic.start = 1'b1;
      @(negedge clk); ic.start = 1'b0;
      k = 1;
      while (ic.done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      chk("c_done_cycle", k, 32'd22);
      chk("c_table", 32'(ic.table_bits), 32'h6);
      @(negedge clk);
      chk("c_valid_after", 32'(ic.table_valid), 32'd1);

      // Reset while vec==3 discards the partial sweep
      @(negedge clk); ia.start = 1'b1;
      @(negedge clk); ia.start = 1'b0;
      k = 0;
      while (ia.vec !== 3'd3 && k < 60) begin @(negedge clk); k++; end
      chk("r_reach_vec3", 32'(ia.vec), 32'd3);
      chk("r_partial_table", 32'(ia.table_bits), 32'h02);
      rst = 1'b1;
      @(negedge clk);
      chk("r_vec", 32'(ia.vec), 32'd0);
      chk("r_busy", 32'(ia.busy), 32'd0);
      chk("r_table", 32'(ia.table_bits), 32'd0);
      chk("r_valid", 32'(ia.table_valid), 32'd0);
      rst = 1'b0;
      sweep_a(1'b0, dc, nd, ve, be);
      chk("r_fresh_done_cycle", dc, 32'd42);
      chk("r_fresh_table", 32'(ia.table_bits), 32'hEA);

      // start pulsed while busy at vec==5 is ignored
      sweep_a(1'b1, dc, nd, ve, be);
      chk("p_done_cycle", dc, 32'd42);
      chk("p_done_count", nd, 32'd1);
      chk("p_vec_seq_errs", ve, 32'd0);
      chk("p_table", 32'(ia.table_bits), 32'hEA);

      // start held high: a new sweep is accepted on the IDLE cycle after DONE
      @(negedge clk); ia.start = 1'b1;
      k = 0;
      while (ia.done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      chk("h_done", 32'(ia.done), 32'd1);
      chk("h_valid_at_done", 32'(ia.table_valid), 32'd1);
      @(negedge clk);
      chk("h_valid_drops", 32'(ia.table_valid), 32'd0);
      chk("h_table_cleared", 32'(ia.table_bits), 32'd0);
      @(negedge clk);
      chk("h_busy_again", 32'(ia.busy), 32'd1);
      ia.start = 1'b0;
      k = 0;
      while (ia.done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      chk("h_second_done", 32'(ia.done), 32'd1);
      chk("h_second_table", 32'(ia.table_bits), 32'hEA);

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
      // Vector 4 stuck at 1: mismatch appears the cycle after vector 4 is sampled
      force4 = 1'b1;
      sweep_a(1'b0, dc, nd, ve, be);
      chk("m_before_v4", 32'(mm25), 32'd0);
      chk("m_after_v4", 32'(mm26), 32'd1);
      chk("m_sticky", 32'(ia.mismatch), 32'd1);
      chk("m_err_idx", 32'(ia.err_idx), 32'd4);
      chk("m_table", 32'(ia.table_bits), 32'hFA);
      force4 = 1'b0;
      sweep_a(1'b0, dc, nd, ve, be);
      chk("m_clean", 32'(ia.mismatch), 32'd0);
      chk("m_clean_table", 32'(ia.table_bits), 32'hEA);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
